minisrc_datapath: RTL and testbench

- 32-bit MiniSRC processor datapath: program counter, 16x32 register file, ALU operand/result registers, write-back register and routing muxes.
- Driven cycle-by-cycle by an external control unit; the instruction register and decode live in the control unit.
- Exposes the memory address and data buses and branch-condition flags back to control.

---
 rtl/minisrc_datapath_if.sv | 30 +++
 rtl/minisrc_datapath.sv | 142 ++++++++++++++
 tb/tb_minisrc_datapath.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/minisrc_datapath_if.sv
// Control/memory bus between the MiniSRC control unit (master) and the datapath (slave).
interface minisrc_datapath_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] iMemData, oMemAddr, oMemData, iImm32;
    logic             iPC_nRst, iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm;
    logic             iRF_Write;
    logic [3:0]       iRF_AddrA, iRF_AddrB, iRF_AddrC;
    logic             iRWB_en;
    logic [3:0]       iALU_Ctrl;
    logic             iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en;
    logic             oJ_zero, oJ_nZero, oJ_pos, oJ_neg;
    logic             oALU_neg, oALU_zero;
    logic             iRMA_en, iRMD_en;
    logic             iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP, iMUX_MAP, iMUX_ASS;

    modport master (
        output iMemData, iImm32, iPC_nRst, iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm,
               iRF_Write, iRF_AddrA, iRF_AddrB, iRF_AddrC, iRWB_en, iALU_Ctrl,
               iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en, iRMA_en, iRMD_en,
               iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP, iMUX_MAP, iMUX_ASS,
        input  oMemAddr, oMemData, oJ_zero, oJ_nZero, oJ_pos, oJ_neg, oALU_neg, oALU_zero
    );

    modport slave (
        input  iMemData, iImm32, iPC_nRst, iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm,
               iRF_Write, iRF_AddrA, iRF_AddrB, iRF_AddrC, iRWB_en, iALU_Ctrl,
               iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en, iRMA_en, iRMD_en,
               iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP, iMUX_MAP, iMUX_ASS,
        output oMemAddr, oMemData, oJ_zero, oJ_nZero, oJ_pos, oJ_neg, oALU_neg, oALU_zero
    );
endinterface

// File: rtl/minisrc_datapath.sv
// MiniSRC datapath: PC, 16-entry register file, operand/result registers and ALU.
// Define DATAPATH_R0_ZERO_EN to make R0 read as zero and ignore writes to it.
module minisrc_datapath #(
    parameter int WIDTH   = 32,
    parameter int PC_STEP = 1
) (
    input logic                iClk,
    input logic                iRst,
    minisrc_datapath_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] pc_q, pc_d, ra_q, ra_d, rb_q, rb_d;
    logic [WIDTH-1:0] rzh_q, rzh_d, rzl_q, rzl_d, ras_q, ras_d, rwb_q, rwb_d;
    logic [WIDTH-1:0] rf_q [16];
    logic [WIDTH-1:0] rf_d [16];

    logic [WIDTH-1:0] rd_a, rd_b, alu_hi, alu_lo, z_rz, z_sel, pc_inc;
    logic [SHW-1:0]   sh;
    logic signed [2*WIDTH-1:0] a_s, b_s, b_div, prod, quo, rem;
    logic [2*WIDTH-1:0] rot_r, rot_l;
    logic unused_bits;

    // Register file read ports
    always_comb begin
        rd_a = rf_q[bus.iRF_AddrA];
        rd_b = rf_q[bus.iRF_AddrB];
`ifdef DATAPATH_R0_ZERO_EN
        if (bus.iRF_AddrA == 4'd0) rd_a = '0;
        if (bus.iRF_AddrB == 4'd0) rd_b = '0;
`endif
    end

    // ALU: operands are sign-extended to double width so MUL/DIV stay well defined
    always_comb begin
        sh    = rb_q[SHW-1:0];
        a_s   = {{WIDTH{ra_q[WIDTH-1]}}, ra_q};
        b_s   = {{WIDTH{rb_q[WIDTH-1]}}, rb_q};
        b_div = (rb_q == '0) ? 2*WIDTH'(1) : b_s;
        prod  = a_s * b_s;
        quo   = a_s / b_div;
        rem   = a_s % b_div;
        rot_r = {ra_q, ra_q} >> sh;
        rot_l = {ra_q, ra_q} << sh;
        alu_hi = '0;
        alu_lo = '0;
        case (bus.iALU_Ctrl)
            4'd0:  alu_lo = ra_q + rb_q;
            4'd1:  alu_lo = ra_q - rb_q;
            4'd2:  alu_lo = ra_q & rb_q;
            4'd3:  alu_lo = ra_q | rb_q;
            4'd4:  alu_lo = ra_q >> sh;
            4'd5:  alu_lo = WIDTH'($signed(ra_q) >>> sh);
            4'd6:  alu_lo = ra_q << sh;
            4'd7:  alu_lo = rot_r[WIDTH-1:0];
            4'd8:  alu_lo = rot_l[2*WIDTH-1:WIDTH];
            4'd9:  {alu_hi, alu_lo} = prod;
            4'd10: begin
                if (rb_q == '0) begin
                    alu_lo = '1;
                    alu_hi = ra_q;
                end else begin
                    alu_lo = quo[WIDTH-1:0];
                    alu_hi = rem[WIDTH-1:0];
                end
            end
            4'd11: alu_lo = -ra_q;
            4'd12: alu_lo = ~ra_q;
            4'd13: alu_lo = rb_q;
            4'd14: alu_lo = ra_q;
            default: alu_lo = '0;
        endcase
    end

    assign unused_bits = ^{quo[2*WIDTH-1:WIDTH], rem[2*WIDTH-1:WIDTH], rot_r[2*WIDTH-1:WIDTH],
                           rot_l[WIDTH-1:0], bus.iRMA_en, bus.iRMD_en};

    // Next-state for every register; all sources are pre-edge values
    always_comb begin
        z_rz   = bus.iMUX_RZHS ? rzh_q : rzl_q;
        z_sel  = bus.iMUX_ASS ? ras_q : z_rz;
        pc_inc = pc_q + WIDTH'(PC_STEP);

        pc_d = pc_q;
        if (!bus.iPC_nRst)
            pc_d = '0;
        else if (bus.iPC_en) begin
            pc_d = pc_inc;
            if (bus.iPC_jmp) begin
                if (bus.iPC_loadRA)       pc_d = ra_q;
                else if (bus.iPC_loadImm) pc_d = pc_inc + bus.iImm32;
            end
        end

        ra_d  = bus.iRA_en  ? rd_a : ra_q;
        rb_d  = bus.iRB_en  ? (bus.iMUX_BIS ? bus.iImm32 : rd_b) : rb_q;
        rzh_d = bus.iRZH_en ? alu_hi : rzh_q;
        rzl_d = bus.iRZL_en ? alu_lo : rzl_q;
        ras_d = bus.iRAS_en ? z_rz : ras_q;
        rwb_d = rwb_q;
        if (bus.iRWB_en)
            rwb_d = bus.iMUX_WBM ? bus.iMemData : (bus.iMUX_WBP ? pc_q : z_sel);

        rf_d = rf_q;
`ifdef DATAPATH_R0_ZERO_EN
        if (bus.iRF_Write && bus.iRF_AddrC != 4'd0) rf_d[bus.iRF_AddrC] = rwb_q;
`else
        if (bus.iRF_Write) rf_d[bus.iRF_AddrC] = rwb_q;
`endif
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            pc_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rzh_q <= '0;
            rzl_q <= '0;
            ras_q <= '0;
            rwb_q <= '0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            ra_q  <= ra_d;
            rb_q  <= rb_d;
            rzh_q <= rzh_d;
            rzl_q <= rzl_d;
            ras_q <= ras_d;
            rwb_q <= rwb_d;
            rf_q  <= rf_d;
        end
    end

    assign bus.oMemAddr  = bus.iMUX_MAP ? pc_q : rzl_q;
    assign bus.oMemData  = rb_q;
    assign bus.oALU_zero = (rzl_q == '0);
    assign bus.oALU_neg  = rzl_q[WIDTH-1];
    assign bus.oJ_zero   = (ra_q == '0);
    assign bus.oJ_nZero  = (ra_q != '0);
    assign bus.oJ_neg    = ra_q[WIDTH-1];
    assign bus.oJ_pos    = !ra_q[WIDTH-1] && (ra_q != '0);
endmodule

// File: tb/tb_minisrc_datapath.sv
// Bench for minisrc_datapath: directed test-plan sequence, then random control words,
// all outputs compared every cycle against a behavioural model of the datapath state.
module tb_minisrc_datapath;
    logic iClk = 1'b0;
    logic iRst = 1'b1;
    int   vec = 0;
    int   err = 0;
    bit   cmp_on = 1'b0;

    minisrc_datapath_if #(.WIDTH(32)) bus();
    minisrc_datapath #(.WIDTH(32), .PC_STEP(1)) dut (.iClk(iClk), .iRst(iRst), .bus(bus));

    always #5 iClk = ~iClk;

    // Behavioural state
    logic [31:0] m_pc, m_ra, m_rb, m_rzh, m_rzl, m_ras, m_rwb;
    logic [31:0] m_rf [16];

    function automatic logic [31:0] rf_rd(input logic [3:0] a);
`ifdef DATAPATH_R0_ZERO_EN
        if (a == 4'd0) return 32'h0;
`endif
        return m_rf[a];
    endfunction

    function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        longint sa, sb, q, r;
        s  = b[4:0];
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0:  return {32'h0, a + b};
            4'd1:  return {32'h0, a - b};
            4'd2:  return {32'h0, a & b};
            4'd3:  return {32'h0, a | b};
            4'd4:  return {32'h0, a >> s};
            4'd5:  return {32'h0, 32'(sa >>> s)};
            4'd6:  return {32'h0, a << s};
            4'd7:  return {32'h0, (a >> s) | (a << (6'd32 - {1'b0, s}))};
            4'd8:  return {32'h0, (a << s) | (a >> (6'd32 - {1'b0, s}))};
            4'd9:  return 64'(sa * sb);
            4'd10: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd11: return {32'h0, 32'h0 - a};
            4'd12: return {32'h0, ~a};
            4'd13: return {32'h0, b};
            4'd14: return {32'h0, a};
            default: return 64'h0;
        endcase
    endfunction

    always @(posedge iClk) begin : model
        logic [63:0] res;
        logic [31:0] zrz, zsel, npc;
        if (iRst) begin
            m_pc <= 0; m_ra <= 0; m_rb <= 0; m_rzh <= 0; m_rzl <= 0; m_ras <= 0; m_rwb <= 0;
            for (int i = 0; i < 16; i++) m_rf[i] <= 32'h0;
        end else begin
            res  = alu_model(bus.iALU_Ctrl, m_ra, m_rb);
            zrz  = bus.iMUX_RZHS ? m_rzh : m_rzl;
            zsel = bus.iMUX_ASS ? m_ras : zrz;
            npc  = m_pc;
            if (!bus.iPC_nRst) npc = 0;
            else if (bus.iPC_en) begin
                if (bus.iPC_jmp && bus.iPC_loadRA)       npc = m_ra;
                else if (bus.iPC_jmp && bus.iPC_loadImm) npc = m_pc + 1 + bus.iImm32;
                else                                     npc = m_pc + 1;
            end
            m_pc <= npc;
            if (bus.iRA_en)  m_ra  <= rf_rd(bus.iRF_AddrA);
            if (bus.iRB_en)  m_rb  <= bus.iMUX_BIS ? bus.iImm32 : rf_rd(bus.iRF_AddrB);
            if (bus.iRZH_en) m_rzh <= res[63:32];
            if (bus.iRZL_en) m_rzl <= res[31:0];
            if (bus.iRAS_en) m_ras <= zrz;
            if (bus.iRWB_en) m_rwb <= bus.iMUX_WBM ? bus.iMemData : (bus.iMUX_WBP ? m_pc : zsel);
`ifdef DATAPATH_R0_ZERO_EN
            if (bus.iRF_Write && bus.iRF_AddrC != 4'd0) m_rf[bus.iRF_AddrC] <= m_rwb;
`else
            if (bus.iRF_Write) m_rf[bus.iRF_AddrC] <= m_rwb;
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge iClk) begin
        if (cmp_on) begin
            chk("oMemAddr", bus.oMemAddr, bus.iMUX_MAP ? m_pc : m_rzl);
            chk("oMemData", bus.oMemData, m_rb);
            chk("oALU_zero", 32'(bus.oALU_zero), 32'(m_rzl == 0));
            chk("oALU_neg", 32'(bus.oALU_neg), 32'(m_rzl[31]));
            chk("oJ_flags", {28'h0, bus.oJ_zero, bus.oJ_nZero, bus.oJ_pos, bus.oJ_neg},
                {28'h0, m_ra == 0, m_ra != 0, !m_ra[31] && m_ra != 0, m_ra[31]});
        end
    end

    task automatic idle();
        bus.iMemData = 0; bus.iImm32 = 0;
        bus.iPC_nRst = 1; bus.iPC_en = 0; bus.iPC_jmp = 0; bus.iPC_loadRA = 0; bus.iPC_loadImm = 0;
        bus.iRF_Write = 0; bus.iRF_AddrA = 0; bus.iRF_AddrB = 0; bus.iRF_AddrC = 0;
        bus.iRWB_en = 0; bus.iALU_Ctrl = 0;
        bus.iRA_en = 0; bus.iRB_en = 0; bus.iRZH_en = 0; bus.iRZL_en = 0; bus.iRAS_en = 0;
        bus.iRMA_en = 0; bus.iRMD_en = 0;
        bus.iMUX_BIS = 0; bus.iMUX_RZHS = 0; bus.iMUX_WBM = 0; bus.iMUX_WBP = 0;
        bus.iMUX_MAP = 0; bus.iMUX_ASS = 0;
    endtask

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic load_reg(input logic [3:0] a, input logic [31:0] v);
        idle(); bus.iMemData = v; bus.iMUX_WBM = 1; bus.iRWB_en = 1; cyc();
        idle(); bus.iRF_Write = 1; bus.iRF_AddrC = a; cyc();
        idle();
    endtask

    task automatic read_rb(input logic [3:0] a);
        idle(); bus.iRB_en = 1; bus.iRF_AddrB = a; cyc(); idle();
    endtask

    // RA <- R[a], RB <- imm, one ALU op into RZH/RZL
    task automatic alu_op(input logic [3:0] a, input logic [31:0] imm, input logic [3:0] op);
        idle(); bus.iRA_en = 1; bus.iRF_AddrA = a; bus.iRB_en = 1; bus.iMUX_BIS = 1; bus.iImm32 = imm; cyc();
        idle(); bus.iALU_Ctrl = op; bus.iRZH_en = 1; bus.iRZL_en = 1; cyc();
        idle();
    endtask

    // Write selected result (hi or lo) into R[c] and bring it onto oMemData via RB
    task automatic z_to_reg(input logic hi, input logic [3:0] c);
        idle(); bus.iMUX_RZHS = hi; bus.iRWB_en = 1; cyc();
        idle(); bus.iRF_Write = 1; bus.iRF_AddrC = c; cyc();
        read_rb(c);
    endtask

    initial begin
        idle();
        iRst = 1; cyc(); cyc();
        iRst = 0; cmp_on = 1;
        bus.iMUX_MAP = 1; #1;
        chk("rst_pc", bus.oMemAddr, 32'h0);
        chk("rst_jzero", 32'(bus.oJ_zero), 32'h1);
        chk("rst_rb", bus.oMemData, 32'h0);

        load_reg(3, 32'h22); load_reg(7, 32'h24); load_reg(4, 32'h28);
        chk("model_r3", m_rf[3], 32'h22);
        read_rb(4); chk("r4_load", bus.oMemData, 32'h28);

        // AND R3 & R7
        idle(); bus.iRA_en = 1; bus.iRF_AddrA = 3; bus.iRB_en = 1; bus.iRF_AddrB = 7; cyc();
        idle(); bus.iALU_Ctrl = 2; bus.iRZH_en = 1; bus.iRZL_en = 1; cyc(); idle(); #1;
        chk("and_rzl", bus.oMemAddr, 32'h20);
        chk("and_zero", 32'(bus.oALU_zero), 32'h0);
        chk("model_and_rzh", m_rzh, 32'h0);
        z_to_reg(0, 4); chk("and_r4", bus.oMemData, 32'h20);

        // Fetch
        idle(); bus.iMUX_MAP = 1; bus.iPC_en = 1; bus.iPC_jmp = 1; #1;
        chk("fetch_addr0", bus.oMemAddr, 32'h0);
        cyc(); chk("fetch_pc1", bus.oMemAddr, 32'h1);
        bus.iPC_nRst = 0; cyc(); chk("pc_clr", bus.oMemAddr, 32'h0);

        // MUL 0x10000 * 0x10000
        load_reg(1, 32'h10000); alu_op(1, 32'h10000, 9); #1;
        chk("mul_rzl", bus.oMemAddr, 32'h0);
        chk("mul_zero", 32'(bus.oALU_zero), 32'h1);
        z_to_reg(1, 5); chk("mul_rzh", bus.oMemData, 32'h1);

        // DIV 7 / 0
        load_reg(1, 32'h7); alu_op(1, 32'h0, 10); #1;
        chk("div0_lo", bus.oMemAddr, 32'hFFFFFFFF);
        chk("div0_neg", 32'(bus.oALU_neg), 32'h1);
        z_to_reg(1, 6); chk("div0_hi", bus.oMemData, 32'h7);

        // ADD 1 + 0xFFFFFFFF
        load_reg(1, 32'h1); alu_op(1, 32'hFFFFFFFF, 0); #1;
        chk("add_wrap", bus.oMemAddr, 32'h0);
        chk("add_zero", 32'(bus.oALU_zero), 32'h1);

        // PC=5 then loadImm 3 -> 9, then loadRA 0x40
        idle(); bus.iPC_nRst = 0; cyc();
        idle(); bus.iPC_en = 1; repeat (5) cyc();
        bus.iMUX_MAP = 1; #1; chk("pc5", bus.oMemAddr, 32'h5);
        bus.iPC_jmp = 1; bus.iPC_loadImm = 1; bus.iImm32 = 3; cyc();
        chk("pc_imm", bus.oMemAddr, 32'h9);
        load_reg(2, 32'h40);
        idle(); bus.iRA_en = 1; bus.iRF_AddrA = 2; cyc();
        idle(); bus.iMUX_MAP = 1; bus.iPC_en = 1; bus.iPC_jmp = 1; bus.iPC_loadRA = 1; bus.iPC_loadImm = 1; cyc();
        chk("pc_ra", bus.oMemAddr, 32'h40);

        // Reset with writes pending
        idle(); bus.iRWB_en = 1; bus.iRF_Write = 1; bus.iRF_AddrC = 3; bus.iMUX_WBM = 1;
        bus.iMemData = 32'hDEAD; bus.iRB_en = 1; bus.iMUX_BIS = 1; bus.iImm32 = 5;
        iRst = 1; cyc(); iRst = 0; idle(); bus.iMUX_MAP = 1; #1;
        chk("rst2_pc", bus.oMemAddr, 32'h0);
        chk("rst2_rb", bus.oMemData, 32'h0);
        chk("rst2_jzero", 32'(bus.oJ_zero), 32'h1);
        read_rb(3); chk("rst2_r3", bus.oMemData, 32'h0);

        // Random control words
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pick [4];
            pick[0] = 0; pick[1] = 32'hFFFFFFFF; pick[2] = 32'h80000000; pick[3] = $urandom;
            bus.iMemData = pick[$urandom_range(0, 3)];
            bus.iImm32 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : pick[$urandom_range(0, 3)];
            bus.iPC_nRst = ($urandom_range(0, 31) != 0);
            bus.iPC_en = 1'($urandom); bus.iPC_jmp = 1'($urandom);
            bus.iPC_loadRA = 1'($urandom); bus.iPC_loadImm = 1'($urandom);
            bus.iRF_Write = 1'($urandom);
            bus.iRF_AddrA = 4'($urandom); bus.iRF_AddrB = 4'($urandom); bus.iRF_AddrC = 4'($urandom);
            bus.iRWB_en = 1'($urandom); bus.iALU_Ctrl = 4'($urandom);
            bus.iRA_en = 1'($urandom); bus.iRB_en = 1'($urandom);
            bus.iRZH_en = 1'($urandom); bus.iRZL_en = 1'($urandom); bus.iRAS_en = 1'($urandom);
            bus.iRMA_en = 1'($urandom); bus.iRMD_en = 1'($urandom);
            bus.iMUX_BIS = 1'($urandom); bus.iMUX_RZHS = 1'($urandom);
            bus.iMUX_WBM = 1'($urandom); bus.iMUX_WBP = 1'($urandom);
            bus.iMUX_MAP = 1'($urandom); bus.iMUX_ASS = 1'($urandom);
            iRst = ($urandom_range(0, 99) == 0);
            cyc();
        end
        iRst = 0; idle(); cyc();
        cmp_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
